// File: rtl/aes_key_sched_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl
// Iterative AES-128 key scheduler and round-key store. Expands one round key
// per cycle from the previous one and serves registered round-key reads.
// Optional feature macro: AES_KEY_ZEROIZE_EN adds zeroize_i, which wipes the
// key store and rk_o and forces IDLE from any state.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no valid key schedule, ready to accept a cipher key
//   EXPAND | computing rk[1..10], one per cycle; new keys are not accepted
//   READY  | all 11 round keys valid; reads granted; a new key may be accepted
// ---------------------------------------------------------------------------
module aes_key_sched_ctrl #(
    parameter int TEXT_WIDTH = 128,
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  key_valid_i,
    output logic                  key_ready_o,
    input  logic [TEXT_WIDTH-1:0] key_i,
    input  logic                  rk_req_i,
    input  logic [IDX_WIDTH-1:0]  rk_idx_i,
    output logic [TEXT_WIDTH-1:0] rk_o,
    output logic                  rk_valid_o,
    output logic                  rk_err_o,
    output logic                  keys_ready_o,
    output logic                  busy_o
`ifdef AES_KEY_ZEROIZE_EN
    ,
    input  logic                  zeroize_i
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ROUNDS);

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_ROM[8*(255-int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [IDX_WIDTH-1:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [1:0]            state_q;
    logic [IDX_WIDTH-1:0]  ctr_q;
    logic [TEXT_WIDTH-1:0] work_q;
    logic [TEXT_WIDTH-1:0] rk_q [0:NUM_ROUNDS];
    logic [TEXT_WIDTH-1:0] next_key;
    logic [TEXT_WIDTH-1:0] rd_data;
    logic                  zero_req;
    logic                  key_accept;
    logic                  rd_grant;
    logic                  rd_reject;

`ifdef AES_KEY_ZEROIZE_EN
    assign zero_req = zeroize_i;
`else
    assign zero_req = 1'b0;
`endif

    assign key_ready_o  = (state_q != ST_EXPAND);
    assign busy_o       = (state_q == ST_EXPAND);
    assign keys_ready_o = (state_q == ST_READY);
    assign key_accept   = key_valid_i && key_ready_o && !zero_req;
    assign rd_grant     = rk_req_i && keys_ready_o && (rk_idx_i <= LAST_IDX) && !zero_req;
    assign rd_reject    = rk_req_i && !rd_grant;

    // One AES-128 expansion round from the most recently written round key.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, t;
        w0 = work_q[127:96];
        w1 = work_q[95:64];
        w2 = work_q[63:32];
        w3 = work_q[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon(ctr_q), 24'h0};
        next_key[127:96] = w0 ^ t;
        next_key[95:64]  = w1 ^ next_key[127:96];
        next_key[63:32]  = w2 ^ next_key[95:64];
        next_key[31:0]   = w3 ^ next_key[63:32];
    end

    // Read mux over the key store; only indices 0..NUM_ROUNDS exist.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (rk_idx_i == IDX_WIDTH'(i)) rd_data = rk_q[i];
        end
    end

    // Sequencer: accept key, count expansion rounds, report completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ctr_q   <= '0;
        end else if (zero_req) begin
            state_q <= ST_IDLE;
            ctr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_READY: begin
                    if (key_accept) begin
                        state_q <= ST_EXPAND;
                        ctr_q   <= IDX_WIDTH'(1);
                    end
                end
                ST_EXPAND: begin
                    if (ctr_q == LAST_IDX) begin
                        state_q <= ST_READY;
                        ctr_q   <= '0;
                    end else begin
                        ctr_q <= ctr_q + IDX_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ctr_q   <= '0;
                end
            endcase
        end
    end

    // Key store and working key; rk[0] on accept, rk[ctr] during expansion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            work_q <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
        end else if (zero_req) begin
            work_q <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
        end else if (key_accept) begin
            work_q  <= key_i;
            rk_q[0] <= key_i;
        end else if (state_q == ST_EXPAND) begin
            work_q <= next_key;
            for (int i = 1; i <= NUM_ROUNDS; i++) begin
                if (ctr_q == IDX_WIDTH'(i)) rk_q[i] <= next_key;
            end
        end
    end

    // Registered read port; reads see the store before any same-edge write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rk_o       <= '0;
            rk_valid_o <= 1'b0;
            rk_err_o   <= 1'b0;
        end else begin
            rk_valid_o <= rd_grant;
            rk_err_o   <= rd_reject;
            if (zero_req)      rk_o <= '0;
            else if (rd_grant) rk_o <= rd_data;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for aes_key_sched_ctrl: directed steps, a read
// scoreboard, and an independent word-by-word key-expansion model.
module tb_aes_key_sched_ctrl;

    logic         clk_i;
    logic         rst_ni;
    logic         key_valid_i;
    logic         key_ready_o;
    logic [127:0] key_i;
    logic         rk_req_i;
    logic [3:0]   rk_idx_i;
    logic [127:0] rk_o;
    logic         rk_valid_o;
    logic         rk_err_o;
    logic         keys_ready_o;
    logic         busy_o;
`ifdef AES_KEY_ZEROIZE_EN
    logic         zeroize_i;
`endif

    aes_key_sched_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .key_valid_i  (key_valid_i),
        .key_ready_o  (key_ready_o),
        .key_i        (key_i),
        .rk_req_i     (rk_req_i),
        .rk_idx_i     (rk_idx_i),
        .rk_o         (rk_o),
        .rk_valid_o   (rk_valid_o),
        .rk_err_o     (rk_err_o),
        .keys_ready_o (keys_ready_o),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize_i    (zeroize_i),
`endif
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K3 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    localparam logic [2047:0] SBOX_TB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct packed {
        logic         ok;
        logic [127:0] data;
    } sb_entry_t;

    sb_entry_t    sb_q [$];
    logic [127:0] exp_rk [0:10];
    logic [127:0] last_rk;
    int           n_tests;
    int           n_fail;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX_TB[8*(255-int'(x)) +: 8];
    endfunction

    // FIPS-197 style recurrence over 44 words, RCON built by xtime.
    task automatic build_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        rc   = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive_read(input logic [3:0] idx, input logic ok, input logic [127:0] data);
        sb_entry_t e;
        rk_req_i = 1'b1;
        rk_idx_i = idx;
        e.ok     = ok;
        e.data   = data;
        sb_q.push_back(e);
    endtask

    // One clock edge; the response to any request driven before it is checked.
    task automatic tick();
        sb_entry_t e;
        int        n;
        n = sb_q.size();
        @(posedge clk_i);
        #1;
        rk_req_i    = 1'b0;
        key_valid_i = 1'b0;
        if (n != 0) begin
            e = sb_q.pop_front();
            if (e.ok) begin
                chk1("rd_valid", rk_valid_o, 1'b1);
                chk1("rd_err_low", rk_err_o, 1'b0);
                chk("rd_data", rk_o, e.data);
                last_rk = e.data;
            end else begin
                chk1("rej_valid_low", rk_valid_o, 1'b0);
                chk1("rej_err", rk_err_o, 1'b1);
                chk("rej_hold", rk_o, last_rk);
            end
        end else begin
            chk1("idle_valid_low", rk_valid_o, 1'b0);
            chk1("idle_err_low", rk_err_o, 1'b0);
        end
    endtask

    // Accept key, then count edges until keys_ready_o (bounded).
    task automatic load_key(input logic [127:0] key, output int cyc);
        key_i       = key;
        key_valid_i = 1'b1;
        tick();
        build_model(key);
        cyc = 0;
        while (!keys_ready_o && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_key_ready"}, key_ready_o, 1'b1);
        chk1({tag, "_busy"}, busy_o, 1'b0);
        chk1({tag, "_keys_ready"}, keys_ready_o, 1'b0);
        chk1({tag, "_rk_valid"}, rk_valid_o, 1'b0);
        chk1({tag, "_rk_err"}, rk_err_o, 1'b0);
        chk({tag, "_rk"}, rk_o, 128'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int           cyc;
        logic [127:0] old10;
        n_tests     = 0;
        n_fail      = 0;
        last_rk     = '0;
        rst_ni      = 1'b0;
        key_valid_i = 1'b0;
        key_i       = '0;
        rk_req_i    = 1'b0;
        rk_idx_i    = '0;
`ifdef AES_KEY_ZEROIZE_EN
        zeroize_i   = 1'b0;
`endif
        @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Known-answer key; a read during EXPAND must be rejected.
        key_i       = K1;
        key_valid_i = 1'b1;
        tick();
        build_model(K1);
        chk1("exp_busy", busy_o, 1'b1);
        chk1("exp_key_ready", key_ready_o, 1'b0);
        drive_read(4'd3, 1'b0, '0);
        tick();
        cyc = 1;
        while (!keys_ready_o && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("k1_latency", 128'(cyc), 128'd10);
        chk1("k1_busy_done", busy_o, 1'b0);
        chk1("k1_key_ready", key_ready_o, 1'b1);

        // Back-to-back reads of all round keys.
        for (int i = 0; i <= 10; i++) begin
            drive_read(4'(i), 1'b1, exp_rk[i]);
            tick();
            if (i == 0)  chk("k1_idx0_is_key", rk_o, K1);
            if (i == 1)  chk("k1_idx1_kat", rk_o, 128'ha0fafe1788542cb123a339392a6c7605);
            if (i == 10) chk("k1_idx10_kat", rk_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        end

        // Out-of-range indices.
        drive_read(4'd11, 1'b0, '0);
        tick();
        drive_read(4'd15, 1'b0, '0);
        tick();
        chk1("oor_keys_ready", keys_ready_o, 1'b1);

        // New key with same-edge read of idx10: old value returned.
        old10       = exp_rk[10];
        key_i       = K2;
        key_valid_i = 1'b1;
        drive_read(4'd10, 1'b1, old10);
        tick();
        build_model(K2);
        chk1("k2_keys_ready_drop", keys_ready_o, 1'b0);
        drive_read(4'd0, 1'b0, '0);
        tick();
        cyc = 1;
        while (!keys_ready_o && cyc < 20) begin
            if (cyc == 3) begin
                key_i       = K3;
                key_valid_i = 1'b1;
            end
            tick();
            cyc++;
        end
        chk("k2_latency", 128'(cyc), 128'd10);
        drive_read(4'd10, 1'b1, exp_rk[10]);
        tick();
        chk("k2_idx10_kat", rk_o, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        drive_read(4'd0, 1'b1, K2);
        tick();
        drive_read(4'd5, 1'b1, exp_rk[5]);
        tick();

        // Reset in the middle of expansion.
        key_i       = K3;
        key_valid_i = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk1("pre_rst_busy", busy_o, 1'b1);
        rst_ni = 1'b0;
        #2;
        check_reset_outputs("midrst");
        last_rk = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        drive_read(4'd2, 1'b0, '0);
        tick();
        load_key(K3, cyc);
        chk("k3_latency", 128'(cyc), 128'd10);
        for (int i = 0; i <= 10; i++) begin
            drive_read(4'(i), 1'b1, exp_rk[i]);
            tick();
        end

`ifdef AES_KEY_ZEROIZE_EN
        // Zeroize in READY beats a same-edge key offer and read.
        zeroize_i   = 1'b1;
        key_i       = K1;
        key_valid_i = 1'b1;
        last_rk     = '0;
        drive_read(4'd4, 1'b0, '0);
        tick();
        zeroize_i = 1'b0;
        chk1("zero_keys_ready", keys_ready_o, 1'b0);
        chk1("zero_busy", busy_o, 1'b0);
        chk1("zero_key_ready", key_ready_o, 1'b1);
        load_key(K1, cyc);
        chk("zero_relatency", 128'(cyc), 128'd10);
        drive_read(4'd10, 1'b1, exp_rk[10]);
        tick();
        chk("zero_idx10_kat", rk_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

        chk("sb_empty", 128'(sb_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
